// File: rtl/sensor_conditioner_if.sv
// Pin-side and FSM-side signals of the sensor conditioner.
// The board/pin side is the master, the conditioner is the slave.
interface sensor_conditioner_if #(
   parameter int unsigned N_SENS = 4
);
   logic [N_SENS-1:0] sens_in;
   logic              sil_in;
   logic [N_SENS-1:0] sensores;
   logic [N_SENS-1:0] sens_rise;
   logic              S;

   modport master (
      output sens_in,
      output sil_in,
      input  sensores,
      input  sens_rise,
      input  S
   );

   modport slave (
      input  sens_in,
      input  sil_in,
      output sensores,
      output sens_rise,
      output S
   );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces N_SENS sensor lines plus the silence button, producing clean
// levels and one-cycle rising-edge pulses in the CLK_ulong domain.
module sensor_conditioner #(
   parameter int unsigned N_SENS  = 4,
   parameter int unsigned DEB_MAX = 50000,
   parameter int unsigned DEB_W   = 16
) (
   input logic                CLK_ulong,
   input logic                reset,
   sensor_conditioner_if.slave bus
);

   // Channel N_SENS is the silence button; channels below it are the sensors.
   localparam int unsigned NCH = N_SENS + 1;
   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_MAX - 1);

   typedef enum logic [1:0] {
      PhIdle,
      PhPending,
      PhAccept
   } phase_e;

   logic [NCH-1:0]   pin;
   logic [NCH-1:0]   sync1_q;
   logic [NCH-1:0]   sync2_q;
   logic [NCH-1:0]   stb_q;
   logic [NCH-1:0]   stb_d;
   logic [NCH-1:0]   pulse_q;
   logic [NCH-1:0]   pulse_d;
   logic [DEB_W-1:0] cnt_q [NCH];
   logic [DEB_W-1:0] cnt_d [NCH];
   phase_e           phase [NCH];

   assign pin = {bus.sil_in, bus.sens_in};

   always_ff @(posedge CLK_ulong or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         stb_q   <= '0;
         pulse_q <= '0;
         for (int c = 0; c < NCH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         sync1_q <= pin;
         sync2_q <= sync1_q;
         stb_q   <= stb_d;
         pulse_q <= pulse_d;
         for (int c = 0; c < NCH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   // Phase of each channel, decoded from the synchronized pin vs. the accepted level.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         phase[c] = PhIdle;
         if (sync2_q[c] != stb_q[c]) begin
            phase[c] = (cnt_q[c] >= CNT_LAST) ? PhAccept : PhPending;
         end
      end
   end

   always_comb begin
      stb_d   = stb_q;
      pulse_d = '0;
      for (int c = 0; c < NCH; c++) begin
         cnt_d[c] = '0;
         unique case (phase[c])
            PhIdle: begin
               cnt_d[c] = '0;
            end
            PhPending: begin
               cnt_d[c] = cnt_q[c] + DEB_W'(1);
            end
            PhAccept: begin
               // Only a 0->1 acceptance pulses; falls just update the level.
               stb_d[c]   = sync2_q[c];
               pulse_d[c] = sync2_q[c];
               cnt_d[c]   = '0;
            end
            default: begin
               cnt_d[c] = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.sensores  = stb_q[N_SENS-1:0];
      bus.sens_rise = pulse_q[N_SENS-1:0];
      bus.S         = pulse_q[N_SENS];
   end

endmodule
